// File: rtl/pc_source_ctrl_if.sv
// Bundle between the main control FSM / memory side and the PC-source
// sequencer. The master modport is the control side, the slave modport is
// pc_source_ctrl itself.
interface pc_source_ctrl_if;
  logic        req_inc;
  logic        req_branch;
  logic        req_jump;
  logic        req_jr;
  logic        req_rte;
  logic        exc_req;
  logic [1:0]  exc_cause;
  logic [31:0] pc_cur;
  logic [31:0] rega;
  logic [7:0]  mem_rdata;

  logic [2:0]  pcsource;
  logic        pc_write;
  logic [31:0] leg5;
  logic [31:0] epc;
  logic [1:0]  cause_reg;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        busy;
  logic        done;

  modport master (
    output req_inc, req_branch, req_jump, req_jr, req_rte,
    output exc_req, exc_cause, pc_cur, rega, mem_rdata,
    input  pcsource, pc_write, leg5, epc, cause_reg,
    input  mem_read, mem_addr, busy, done
  );

  modport slave (
    input  req_inc, req_branch, req_jump, req_jr, req_rte,
    input  exc_req, exc_cause, pc_cur, rega, mem_rdata,
    output pcsource, pc_write, leg5, epc, cause_reg,
    output mem_read, mem_addr, busy, done
  );
endinterface

// File: rtl/pc_source_ctrl.sv
// PC-source sequencer: drives the multicycle PC mux select and PC write
// enable, owns EPC / cause / handler-vector registers and runs the
// exception entry sequence SAVE -> FETCH -> LOAD -> DRIVE.
// All outputs are registered; a request sampled in IDLE shows up on the
// outputs in the following cycle.
// Optional feature: define PCSRC_ALIGN_CHECK_EN to turn a misaligned jr
// target (rega[1:0]!=0) or misaligned EPC on rte into a cause-3 exception.
module pc_source_ctrl #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned VEC_BASE   = 253,
  parameter int unsigned EPC_OFFSET = 4
) (
  input logic             clk,
  input logic             reset,
  pc_source_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE, S_FETCH, S_LOAD, S_DRIVE
  } state_t;

  localparam logic [2:0] LEG_NONE   = 3'b000;
  localparam logic [2:0] LEG_BRANCH = 3'b001;
  localparam logic [2:0] LEG_INC    = 3'b010;
  localparam logic [2:0] LEG_JR     = 3'b011;
  localparam logic [2:0] LEG_JUMP   = 3'b100;
  localparam logic [2:0] LEG_5      = 3'b101;

  localparam int unsigned     CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic [31:0]      r_epc,       w_epc_nxt;
  logic [1:0]       r_cause,     w_cause_nxt;
  logic [2:0]       r_pcsource,  w_pcsource_nxt;
  logic             r_pc_write,  w_pc_write_nxt;
  logic [31:0]      r_leg5,      w_leg5_nxt;
  logic             r_mem_read,  w_mem_read_nxt;
  logic [31:0]      r_mem_addr,  w_mem_addr_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             r_done,      w_done_nxt;

  logic             w_jr_misaligned;
  logic             w_rte_misaligned;
  logic [1:0]       w_vec_idx;
  logic             w_take_exc;
  logic [1:0]       w_new_cause;
  logic [2:0]       w_leg;

`ifdef PCSRC_ALIGN_CHECK_EN
  assign w_jr_misaligned  = (bus.rega[1:0] != 2'b00);
  assign w_rte_misaligned = (r_epc[1:0] != 2'b00);
  assign w_vec_idx        = r_cause;
`else
  assign w_jr_misaligned  = 1'b0;
  assign w_rte_misaligned = 1'b0;
  // Cause 3 is reserved without the alignment check; it uses the cause-0 vector.
  assign w_vec_idx        = (r_cause == 2'd3) ? 2'd0 : r_cause;
`endif

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_epc_nxt      = r_epc;
    w_cause_nxt    = r_cause;
    w_pcsource_nxt = LEG_NONE;
    w_pc_write_nxt = 1'b0;
    w_leg5_nxt     = r_leg5;
    w_mem_read_nxt = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_busy_nxt     = 1'b1;
    w_done_nxt     = 1'b0;
    w_take_exc     = 1'b0;
    w_new_cause    = bus.exc_cause;
    w_leg          = LEG_NONE;

    unique case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        // Fixed priority: exception, rte, jr, jump, branch, inc.
        if (bus.exc_req) begin
          w_take_exc = 1'b1;
        end else if (bus.req_rte) begin
          if (w_rte_misaligned) begin
            w_take_exc  = 1'b1;
            w_new_cause = 2'd3;
          end else begin
            w_leg      = LEG_5;
            w_leg5_nxt = r_epc;
          end
        end else if (bus.req_jr) begin
          if (w_jr_misaligned) begin
            w_take_exc  = 1'b1;
            w_new_cause = 2'd3;
          end else begin
            w_leg = LEG_JR;
          end
        end else if (bus.req_jump) begin
          w_leg = LEG_JUMP;
        end else if (bus.req_branch) begin
          w_leg = LEG_BRANCH;
        end else if (bus.req_inc) begin
          w_leg = LEG_INC;
        end

        if (w_take_exc) begin
          w_state_nxt = S_SAVE;
          w_epc_nxt   = bus.pc_cur - 32'(EPC_OFFSET);
          w_cause_nxt = w_new_cause;
          w_busy_nxt  = 1'b1;
        end else if (w_leg != LEG_NONE) begin
          w_pcsource_nxt = w_leg;
          w_pc_write_nxt = 1'b1;
          w_done_nxt     = 1'b1;
        end
      end

      S_SAVE: begin
        w_state_nxt    = S_FETCH;
        w_mem_read_nxt = 1'b1;
        w_mem_addr_nxt = 32'(VEC_BASE) + {30'b0, w_vec_idx};
        w_cnt_nxt      = CNT_LOAD;
      end

      S_FETCH: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_cnt_nxt      = r_cnt - 1'b1;
          w_mem_read_nxt = 1'b1;
        end
      end

      S_LOAD: begin
        w_state_nxt    = S_DRIVE;
        w_leg5_nxt     = {24'b0, bus.mem_rdata};
        w_pcsource_nxt = LEG_5;
        w_pc_write_nxt = 1'b1;
        w_done_nxt     = 1'b1;
      end

      S_DRIVE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_epc      <= '0;
      r_cause    <= '0;
      r_pcsource <= LEG_NONE;
      r_pc_write <= 1'b0;
      r_leg5     <= '0;
      r_mem_read <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_epc      <= w_epc_nxt;
      r_cause    <= w_cause_nxt;
      r_pcsource <= w_pcsource_nxt;
      r_pc_write <= w_pc_write_nxt;
      r_leg5     <= w_leg5_nxt;
      r_mem_read <= w_mem_read_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.pcsource  = r_pcsource;
  assign bus.pc_write  = r_pc_write;
  assign bus.leg5      = r_leg5;
  assign bus.epc       = r_epc;
  assign bus.cause_reg = r_cause;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
